// File: rtl/multiword_add_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// multiword_add_pkg
// Shared definitions for the multi-word add/subtract sequencer:
//   - state_t      : sequencer FSM states (IDLE, RUN, DONE)
//   - DEF_N        : default slice width in bits
//   - DEF_WORDS    : default number of words per operation
//   - DEF_CNT_W    : default word-counter width (2**DEF_CNT_W >= DEF_WORDS)
// -----------------------------------------------------------------------------
package multiword_add_pkg;

   localparam int DEF_N     = 32;
   localparam int DEF_WORDS = 4;
   localparam int DEF_CNT_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// -----------------------------------------------------------------------------
// multiword_add_sequencer_if
// Bundles the control, operand-stream and result-stream signals of the
// sequencer.
//   master : operand source / result sink side (drives start, sub, abort,
//            in_valid, a_word, b_word)
//   slave  : sequencer side (drives in_ready, out_valid, s_word, s_last,
//            busy, done, carryout, overflow)
// Parameter N is the word width and must match the sequencer's N.
// -----------------------------------------------------------------------------
interface multiword_add_sequencer_if import multiword_add_pkg::*; #(
   parameter int N = DEF_N
);

   logic         start;
   logic         sub;
   logic         abort;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a_word;
   logic [N-1:0] b_word;
   logic         out_valid;
   logic [N-1:0] s_word;
   logic         s_last;
   logic         busy;
   logic         done;
   logic         carryout;
   logic         overflow;

   modport master (
      output start, sub, abort, in_valid, a_word, b_word,
      input  in_ready, out_valid, s_word, s_last, busy, done, carryout, overflow
   );

   modport slave (
      input  start, sub, abort, in_valid, a_word, b_word,
      output in_ready, out_valid, s_word, s_last, busy, done, carryout, overflow
   );

endinterface

// File: rtl/multiword_add_sequencer_slice.sv
// -----------------------------------------------------------------------------
// nbit_add_slice
// Purely combinational N-bit adder slice with carry-in.
//   carryin  : carry into bit 0
//   x, y     : N-bit addends
//   s        : N-bit sum (wraps modulo 2**N)
//   carryout : carry out of bit N-1
//   overflow : carry into bit N-1 XOR carry out of bit N-1 (two's-complement
//              overflow of this slice)
// -----------------------------------------------------------------------------
module nbit_add_slice import multiword_add_pkg::*; #(
   parameter int N = DEF_N
) (
   input  logic         carryin,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   output logic [N-1:0] s,
   output logic         carryout,
   output logic         overflow
);

   // The add is split at the MSB so the carry into bit N-1 is available
   // explicitly for the overflow flag.
   logic msb_carry_in;

   assign {msb_carry_in, s[N-2:0]} = {1'b0, x[N-2:0]} + {1'b0, y[N-2:0]}
                                   + {{(N-1){1'b0}}, carryin};
   assign {carryout, s[N-1]}       = {1'b0, x[N-1]} + {1'b0, y[N-1]}
                                   + {1'b0, msb_carry_in};
   assign overflow                 = msb_carry_in ^ carryout;

endmodule

// File: rtl/multiword_add_sequencer.sv
// -----------------------------------------------------------------------------
// multiword_add_sequencer
// Performs a WORDS*N-bit add or subtract by streaming operand words (LSW
// first) through a single N-bit slice, chaining the carry through carry_reg.
// One sum word is emitted per accepted operand word, one cycle later; the
// final word carries s_last/done together with the carry-out and signed
// overflow of the full-width operation.
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave modport of multiword_add_sequencer_if
//              (start/sub/abort control, in_valid/in_ready/a_word/b_word
//               operand stream, out_valid/s_word/s_last result stream,
//               busy/done/carryout/overflow status)
// Parameters: N word width, WORDS words per operation (>= 2), CNT_W counter
// width with 2**CNT_W >= WORDS.
// -----------------------------------------------------------------------------
module multiword_add_sequencer import multiword_add_pkg::*; #(
   parameter int N     = DEF_N,
   parameter int WORDS = DEF_WORDS,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                        clock,
   input  logic                        reset_n,
   multiword_add_sequencer_if.slave    bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             carry_reg;
   logic             sub_reg;
   logic [N-1:0]     s_word_reg;
   logic             out_valid_reg;
   logic             s_last_reg;
   logic             done_reg;
   logic             busy_reg;
   logic             carryout_reg;
   logic             overflow_reg;

   logic [N-1:0]     y_word;
   logic [N-1:0]     slice_s;
   logic             slice_carry;
   logic             slice_overflow;
   logic             accept;

   // Subtraction is A + ~B + 1; the +1 comes from carry_reg being seeded
   // with sub at start.
   assign y_word = sub_reg ? ~bus.b_word : bus.b_word;

   nbit_add_slice #(.N(N)) u_slice (
      .carryin  (carry_reg),
      .x        (bus.a_word),
      .y        (y_word),
      .s        (slice_s),
      .carryout (slice_carry),
      .overflow (slice_overflow)
   );

   // abort takes priority over an operand word in the same cycle.
   assign accept = (state_reg == RUN) && bus.in_valid && !bus.abort;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         carry_reg     <= 1'b0;
         sub_reg       <= 1'b0;
         s_word_reg    <= '0;
         out_valid_reg <= 1'b0;
         s_last_reg    <= 1'b0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         carryout_reg  <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         // Per-word pulses default low; they are raised only by an accept.
         out_valid_reg <= 1'b0;
         s_last_reg    <= 1'b0;
         done_reg      <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  state_reg    <= RUN;
                  sub_reg      <= bus.sub;
                  carry_reg    <= bus.sub;
                  cnt_reg      <= '0;
                  carryout_reg <= 1'b0;
                  overflow_reg <= 1'b0;
                  busy_reg     <= 1'b1;
               end
            end

            RUN: begin
               if (bus.abort) begin
                  state_reg    <= IDLE;
                  busy_reg     <= 1'b0;
                  carryout_reg <= 1'b0;
                  overflow_reg <= 1'b0;
               end else if (accept) begin
                  s_word_reg    <= slice_s;
                  out_valid_reg <= 1'b1;
                  carry_reg     <= slice_carry;
                  cnt_reg       <= cnt_reg + 1'b1;
                  if (cnt_reg == LAST_CNT) begin
                     // Only the final word's flags describe the full operand.
                     s_last_reg   <= 1'b1;
                     done_reg     <= 1'b1;
                     carryout_reg <= slice_carry;
                     overflow_reg <= slice_overflow;
                     state_reg    <= DONE;
                  end
               end
            end

            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               if (bus.abort) begin
                  carryout_reg <= 1'b0;
                  overflow_reg <= 1'b0;
               end
            end

            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   // in_ready decodes from state alone; everything else is a register.
   assign bus.in_ready  = (state_reg == RUN);
   assign bus.out_valid = out_valid_reg;
   assign bus.s_word    = s_word_reg;
   assign bus.s_last    = s_last_reg;
   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.carryout  = carryout_reg;
   assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multiword_add_sequencer
// Directed bench for multiword_add_sequencer with N=8, WORDS=4. Expected sum
// words are computed from a 32-bit reference add and queued when an operation
// is started; they are popped and compared whenever out_valid is observed.
// -----------------------------------------------------------------------------
module tb_multiword_add_sequencer;
   import multiword_add_pkg::*;

   localparam int N     = 8;
   localparam int WORDS = 4;
   localparam int CNT_W = 2;

   logic clock;
   logic reset_n;

   multiword_add_sequencer_if #(.N(N)) ifc ();

   multiword_add_sequencer #(.N(N), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0] sb_word[$];
   logic         sb_last[$];
   logic         exp_co;
   logic         exp_ov;
   int           cyc;
   int           done_cnt;
   int           done_cyc_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample #1 after the edge, and score any output.
   task automatic tick();
      logic [N-1:0] w;
      logic         l;
      @(posedge clock);
      #1;
      cyc++;
      if (ifc.out_valid === 1'b1) begin
         check("sb_nonempty", 32'(sb_word.size() > 0), 32'd1);
         if (sb_word.size() > 0) begin
            w = sb_word.pop_front();
            l = sb_last.pop_front();
            $display("word: s_word=%02h s_last=%0b exp_word=%02h exp_last=%0b",
                     ifc.s_word, ifc.s_last, w, l);
            check("s_word", 32'(ifc.s_word), 32'(w));
            check("s_last", 32'(ifc.s_last), 32'(l));
         end
      end
      if (ifc.done === 1'b1) begin
         done_cnt++;
         done_cyc_seen = cyc;
         check("carryout", 32'(ifc.carryout), 32'(exp_co));
         check("overflow", 32'(ifc.overflow), 32'(exp_ov));
      end
   endtask

   // Reference model: full-width add of A and (sub ? ~B : B) plus sub.
   task automatic push_expected(input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input int nwords);
      logic [31:0] bb;
      logic [32:0] full;
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + 33'(sub);
      exp_co = full[32];
      exp_ov = (a[31] == bb[31]) && (full[31] != a[31]);
      for (int w = 0; w < nwords; w++) begin
         sb_word.push_back(full[8*w +: 8]);
         sb_last.push_back(w == WORDS - 1);
      end
   endtask

   task automatic start_op(input logic sub);
      ifc.start = 1'b1;
      ifc.sub   = sub;
      tick();
      cyc       = 0;
      done_cnt  = 0;
      done_cyc_seen = -1;
      ifc.start = 1'b0;
      check("in_ready_run", 32'(ifc.in_ready), 32'd1);
      check("busy_run", 32'(ifc.busy), 32'd1);
   endtask

   task automatic drive_word(input logic [31:0] a, input logic [31:0] b, input int w);
      ifc.in_valid = 1'b1;
      ifc.a_word   = a[8*w +: 8];
      ifc.b_word   = b[8*w +: 8];
      tick();
      ifc.in_valid = 1'b0;
   endtask

   // Full operation with 'gap' idle cycles between words; when poke is set a
   // start (with the opposite sub) is presented during a stall.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input int gap, input logic poke);
      int exp_cyc;
      push_expected(a, b, sub, WORDS);
      start_op(sub);
      for (int w = 0; w < WORDS; w++) begin
         drive_word(a, b, w);
         if (w < WORDS - 1) begin
            for (int g = 0; g < gap; g++) begin
               if (poke && g == 0) begin
                  ifc.start = 1'b1;
                  ifc.sub   = ~sub;
               end
               tick();
               ifc.start = 1'b0;
               check("in_ready_stall", 32'(ifc.in_ready), 32'd1);
            end
         end
      end
      tick();
      // Counting the start cycle as cycle 1, done lands on 5 (no stalls)
      // or 14 (3 stalls between words).
      exp_cyc = WORDS + (WORDS - 1) * gap;
      $display("op: a=%08h b=%08h sub=%0b done_cyc=%0d co=%0b ov=%0b",
               a, b, sub, done_cyc_seen, ifc.carryout, ifc.overflow);
      check("done_count", 32'(done_cnt), 32'd1);
      check("done_latency", 32'(done_cyc_seen), 32'(exp_cyc));
      check("busy_after", 32'(ifc.busy), 32'd0);
      check("in_ready_after", 32'(ifc.in_ready), 32'd0);
      check("out_valid_after", 32'(ifc.out_valid), 32'd0);
      check("carryout_held", 32'(ifc.carryout), 32'(exp_co));
      check("overflow_held", 32'(ifc.overflow), 32'(exp_ov));
      check("sb_drained", 32'(sb_word.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  32'(ifc.in_ready),  32'd0);
      check({tag, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
      check({tag, "_s_word"},    32'(ifc.s_word),    32'd0);
      check({tag, "_s_last"},    32'(ifc.s_last),    32'd0);
      check({tag, "_busy"},      32'(ifc.busy),      32'd0);
      check({tag, "_done"},      32'(ifc.done),      32'd0);
      check({tag, "_carryout"},  32'(ifc.carryout),  32'd0);
      check({tag, "_overflow"},  32'(ifc.overflow),  32'd0);
   endtask

   initial begin
      reset_n      = 1'b0;
      ifc.start    = 1'b0;
      ifc.sub      = 1'b0;
      ifc.abort    = 1'b0;
      ifc.in_valid = 1'b0;
      ifc.a_word   = '0;
      ifc.b_word   = '0;
      cyc          = 0;
      done_cnt     = 0;
      done_cyc_seen = -1;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // Main function
      run_op(32'h00FFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
      run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
      run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
      run_op(32'h00000000, 32'h00000001, 1'b1, 0, 1'b0);
      run_op(32'h80000000, 32'h00000001, 1'b1, 0, 1'b0);

      // Stalls between words, with a start presented mid-operation
      run_op(32'h00FFFFFF, 32'h00000001, 1'b0, 3, 1'b1);

      // start and abort together in IDLE: stays idle
      ifc.start = 1'b1;
      ifc.abort = 1'b1;
      tick();
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      check("start_abort_busy", 32'(ifc.busy), 32'd0);
      check("start_abort_ready", 32'(ifc.in_ready), 32'd0);
      tick();
      check("start_abort_idle", 32'(ifc.in_ready), 32'd0);

      // Abort after two accepted words; the word presented with abort is dropped
      push_expected(32'h12345678, 32'h11111111, 1'b0, 2);
      start_op(1'b0);
      drive_word(32'h12345678, 32'h11111111, 0);
      drive_word(32'h12345678, 32'h11111111, 1);
      ifc.abort    = 1'b1;
      ifc.in_valid = 1'b1;
      ifc.a_word   = 8'h34;
      ifc.b_word   = 8'h11;
      tick();
      ifc.abort    = 1'b0;
      ifc.in_valid = 1'b0;
      $display("abort: busy=%0b in_ready=%0b out_valid=%0b done=%0b",
               ifc.busy, ifc.in_ready, ifc.out_valid, ifc.done);
      check("abort_in_ready", 32'(ifc.in_ready), 32'd0);
      check("abort_busy", 32'(ifc.busy), 32'd0);
      check("abort_out_valid", 32'(ifc.out_valid), 32'd0);
      check("abort_done", 32'(ifc.done), 32'd0);
      check("abort_carryout", 32'(ifc.carryout), 32'd0);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_sb_drained", 32'(sb_word.size()), 32'd0);
      run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);

      // Asynchronous reset mid-RUN, after the previous op left carryout set
      push_expected(32'hA5A5A5A5, 32'h01010101, 1'b0, 1);
      start_op(1'b0);
      drive_word(32'hA5A5A5A5, 32'h01010101, 0);
      #3;
      reset_n = 1'b0;
      #1;
      $display("reset mid-run: busy=%0b s_word=%02h", ifc.busy, ifc.s_word);
      check_all_zero("midrst");
      sb_word.delete();
      sb_last.delete();
      tick();
      reset_n = 1'b1;
      tick();
      run_op(32'h80000000, 32'h00000001, 1'b1, 0, 1'b0);
      run_op(32'h0000FF80, 32'h00000080, 1'b0, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Sequences a single N-bit add slice with carry-out and overflow across WORDS operand words to perform WORDS×N-bit addition or subtraction. Operand words are streamed in least-significant word first, and the carry is chained through a register between words. Sum words come out one per accepted input, and the final carry-out and signed overflow are flagged at the end. The block sits between an operand source (memory or FIFO) and a result sink in the multi-precision arithmetic datapath.

## Interface
- N, 32, word width of the add slice (bits).
- WORDS, 4, number of words per operation (≥2).
- CNT_W, 2, word counter width; must satisfy 2^CNT_W ≥ WORDS.
- clock  in  1  rising-edge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin an operation; sampled only in IDLE.
- sub  in  1  sampled with start: 0 = A+B, 1 = A−B.
- abort  in  1  synchronous cancel; returns to IDLE without done.
- in_valid  in  1  a_word/b_word valid.
- in_ready  out  1  block accepts a word this cycle.
- a_word  in  N  operand A word, LSW first.
- b_word  in  N  operand B word, LSW first.
- out_valid  out  1  s_word valid; one-cycle pulse per word, no backpressure.
- s_word  out  N  sum word.
- s_last  out  1  marks the final sum word.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse with the final word.
- carryout  out  1  carry out of the MSB of the full operation; valid with done, held until the next start.
- overflow  out  1  two's-complement overflow of the full operation; valid with done, held until the next start.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - On start=1: latch sub, set carry_reg=sub, cnt=0, clear carryout/overflow, go to RUN.
- RUN:
  - in_ready=1, busy=1.
  - Accept a word when in_valid & in_ready.
  - Slice computes S = A + (sub ? ~B : B) + carry_reg, with N-bit wraparound.
  - On accept: register S into s_word, pulse out_valid next cycle, set carry_reg to the slice carry-out, increment cnt.
  - Accept with cnt==WORDS−1: register the slice carryout and overflow of that word into the outputs, and set s_last. Go to DONE.
  - in_valid=0: nothing changes; carry_reg and cnt hold indefinitely.
- DONE:
  - out_valid=1, s_last=1, done=1, busy=1, in_ready=0.
  - Next cycle: IDLE.
- Slice flags:
  - carry = carry out of bit N−1.
  - overflow = carry into bit N−1 XOR carry out of bit N−1.
  - Only the flags of the final word are reported.
- Subtraction: carryout=1 means no borrow (A ≥ B unsigned).
- start while not in IDLE: ignored. start and abort together in IDLE: abort wins, so the block stays in IDLE.
- abort in RUN or DONE:
  - Next state IDLE; out_valid, s_last and done forced to 0 next cycle.
  - carryout/overflow are cleared.
  - A word presented in the same cycle as abort is not accepted.
- reset_n=0 at any time: immediately IDLE. All outputs 0, carry_reg=0, cnt=0.

## Timing
- Reset values: in_ready=0, out_valid=0, s_word=0, s_last=0, busy=0, done=0, carryout=0, overflow=0.
- start sampled at edge T. in_ready is high from cycle T+1.
- Each accepted word produces out_valid/s_word exactly one cycle later.
- Back-to-back in_valid:
  - Words are accepted on cycles T+1 … T+WORDS.
  - done, s_last and the last s_word appear at cycle T+WORDS+1.
  - IDLE at T+WORDS+2; the next start can be accepted on that edge.
- All outputs are registered. There is no combinational path from inputs to outputs except in_ready, which decodes from state only.

## Structure
- Package multiword_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparams for default N/WORDS.
- One sub-module, nbit_add_slice: purely combinational.
  - Inputs: carryin, X[N], Y[N].
  - Outputs: S[N], carryout, overflow (per the slice flag rules above).
- The sequencer holds the FSM, cnt, carry_reg, the sub latch, the B-inversion mux and the output registers.

## Test plan
All cases use N=8, WORDS=4. Operands are shown as 32-bit values streamed LSW first.
- Basic add: 0x00FFFFFF + 0x00000001, sub=0, back-to-back words.
  - s_word = 00,00,00,01; s_last on the 4th word.
  - carryout=0, overflow=0; done 5 cycles after start.
- Signed overflow: 0x7FFFFFFF + 0x00000001.
  - s_word = 00,00,00,80; overflow=1, carryout=0.
- Carry out: 0xFFFFFFFF + 0x00000001.
  - s_word = 00,00,00,00; carryout=1, overflow=0.
- Subtract with borrow: 0x00000000 − 0x00000001, sub=1.
  - s_word = FF,FF,FF,FF; carryout=0, overflow=0.
  - Same values with 0x80000000 − 0x00000001 gives 0x7FFFFFFF with overflow=1.
- Stalls: repeat the basic add with in_valid low for 3 cycles between each word.
  - Identical s_words and flags.
  - done 14 cycles after start; in_ready stays 1 throughout RUN.
- Cancel and reset:
  - abort after 2 accepted words: no done, IDLE next cycle.
  - reset_n pulsed low mid-RUN: all outputs 0 immediately.
  - A fresh start then yields correct results in both cases.
  - start while busy has no effect.
